// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg : shared constants and types for the instruction-fetch stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package if_pkg;

    localparam logic [2:0] PC_SEL_SEQ = 3'd0;
    localparam logic [2:0] PC_SEL_BR  = 3'd1;
    localparam logic [2:0] PC_SEL_J   = 3'd2;
    localparam logic [2:0] PC_SEL_JR  = 3'd3;
    localparam logic [2:0] PC_SEL_IRQ = 3'd4;
    localparam logic [2:0] PC_SEL_EXC = 3'd5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
        logic        misalign;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc_plus4: 32'h0000_0000,
        valid:    1'b0,
        misalign: 1'b0
    };

    // Bit 31 is the supervisor bit and never changes by sequential increment.
    function automatic logic [31:0] pc_inc4(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg : IF/ID pipeline register, flush has priority over stall
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_id_reg
    import if_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= IF_ID_BUBBLE;
        end else if (flush) begin
            r_q <= IF_ID_BUBBLE;
        end else if (!stall) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : PC register, next-PC select and IF/ID capture.
// Optional fetch-alignment check enabled by macro IF_ALIGN_CHK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] IRQ_VECTOR = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        if_id_misalign
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_redirect;
    logic        w_misalign;
    if_id_t      w_fetch;
    if_id_t      w_if_id;

    assign w_pc_plus4 = pc_inc4(r_pc);

    // Codes 6/7 alias sequential fetch, so they must not override a stall.
    assign w_redirect = (pc_sel != PC_SEL_SEQ) && (pc_sel <= PC_SEL_EXC);

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (pc_sel)
            PC_SEL_BR:  w_pc_next = branch_target;
            PC_SEL_J:   w_pc_next = {w_pc_plus4[31:28], jump_index, 2'b00};
            PC_SEL_JR:  w_pc_next = {jr_target[31] & r_pc[31], jr_target[30:0]};
            PC_SEL_IRQ: w_pc_next = IRQ_VECTOR;
            PC_SEL_EXC: w_pc_next = EXC_VECTOR;
            default:    w_pc_next = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_pc_next;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

`ifdef IF_ALIGN_CHK_EN
    assign w_misalign = |r_pc[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // A misaligned fetch still carries valid=1 so the fault reaches the exception unit.
    assign w_fetch.instr    = w_misalign ? NOP_INSTR : rom_data;
    assign w_fetch.pc_plus4 = w_pc_plus4;
    assign w_fetch.valid    = 1'b1;
    assign w_fetch.misalign = w_misalign;

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .d     (w_fetch),
        .q     (w_if_id)
    );

    assign rom_addr       = r_pc;
    assign pc             = r_pc;
    assign if_id_instr    = w_if_id.instr;
    assign if_id_pc_plus4 = w_if_id.pc_plus4;
    assign if_id_valid    = w_if_id.valid;
    assign if_id_misalign = w_if_id.misalign;

endmodule

`default_nettype wire
